// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift arbiter controller.
package shift_ctrl_pkg;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic             left;
        logic [LEN_W-1:0] len;
        logic             id;
    } job_t;

    // A zero or oversized length request runs the full register width.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(MAX_LEN)) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Loadable bidirectional shift register with serial in/out.
module shift_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             left,
    input  logic             sdi,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sdo
);

    logic [WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (shift_en) begin
            if (left) begin
                q_d = {q_q[WIDTH-2:0], sdi};
            end else begin
                q_d = {sdi, q_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign sdo = left ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Two-requester round-robin front end driving a serial shift job,
// returning the final register value on a valid/ready response.
module shift_arbiter_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_left,
    input  logic [3:0]       a_len,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_left,
    input  logic [3:0]       b_len,
    input  logic             sdi,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             id_q, id_d;

    logic             grant_b;
    logic             load;
    logic             shift_en;
    job_t             job;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] core_q;
    logic             core_sdo;

    // Pointer only matters when both ask; a lone requester always wins.
    assign grant_b   = b_valid & (~a_valid | ptr_q);
    assign load_data = grant_b ? b_data : a_data;

    always_comb begin
        job.left = grant_b ? b_left : a_left;
        job.len  = eff_len(grant_b ? b_len : a_len);
        job.id   = grant_b;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        id_d      = id_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        sdo_valid = 1'b0;
        sdo       = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (a_valid || b_valid) begin
                    a_ready = ~grant_b;
                    b_ready = grant_b;
                    load    = 1'b1;
                    ptr_d   = ~grant_b;
                    dir_d   = job.left;
                    cnt_d   = job.len;
                    id_d    = job.id;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en  = 1'b1;
                sdo_valid = 1'b1;
                sdo       = core_sdo;
                cnt_d     = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are quiet for as long as reset is held, not just after the edge.
        if (!reset_n) begin
            a_ready   = 1'b0;
            b_ready   = 1'b0;
            sdo_valid = 1'b0;
            sdo       = 1'b0;
            rsp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            id_q    <= id_d;
        end
    end

    assign rsp_data = rsp_valid ? core_q : '0;
    assign rsp_id   = rsp_valid & id_q;

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .shift_en (shift_en),
        .left     (dir_q),
        .sdi      (sdi),
        .d        (load_data),
        .q        (core_q),
        .sdo      (core_sdo)
    );

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Directed bench for shift_arbiter_ctrl with hand-computed expectations.
module tb_shift_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [7:0] a_data, b_data;
    logic       a_left, b_left;
    logic [3:0] a_len, b_len;
    logic       sdi;
    logic       sdo, sdo_valid;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_arbiter_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_left    (a_left),
        .a_len     (a_len),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_left    (b_left),
        .b_len     (b_len),
        .sdi       (sdi),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return 32'({a_ready, b_ready, sdo, sdo_valid, rsp_valid, rsp_id, rsp_data});
    endfunction

    // Launches one job, checks the serial stream, stops with the DUT in DONE.
    task automatic run_job(input string tag, input logic use_b,
                           input logic [7:0] d, input logic left,
                           input logic [3:0] len, input logic s,
                           input logic [7:0] bits, input int n,
                           input logic [7:0] exp_d);
        int cyc;
        cyc = 0;
        sdi = s;
        if (use_b) begin
            b_valid = 1'b1; b_data = d; b_left = left; b_len = len;
        end else begin
            a_valid = 1'b1; a_data = d; a_left = left; a_len = len;
        end
        #1;
        check_eq({tag, "_grant"}, 32'({a_ready, b_ready}),
                 use_b ? 32'h1 : 32'h2);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = ~d; b_data = ~d;
        a_left = ~left; b_left = ~left;
        a_len = 4'd2; b_len = 4'd2;
        #1;
        while (!rsp_valid && cyc < 20) begin
            check_eq({tag, "_sdo_valid"}, 32'(sdo_valid), 32'h1);
            if (cyc < 8) check_eq({tag, "_sdo"}, 32'(sdo), 32'(bits[7-cyc]));
            check_eq({tag, "_rdy_busy"}, 32'({a_ready, b_ready}), 32'h0);
            cyc++;
            tick();
        end
        check_eq({tag, "_shift_cycles"}, 32'(cyc), 32'(n));
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_d));
        check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'(use_b));
        check_eq({tag, "_sdo_idle"}, 32'({sdo, sdo_valid}), 32'h0);
    endtask

    initial begin
        int ng, both, longp;
        logic prev;
        logic [3:0] gs;

        reset_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b0;
        a_data = '0; b_data = '0;
        a_left = 1'b0; b_left = 1'b0;
        a_len = '0; b_len = '0;
        sdi = 1'b0; rsp_ready = 1'b0;
        tick();
        tick();
        check_eq("reset_outs", all_out(), 32'h0);
        a_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Left shift, A only, then response backpressure
        run_job("left_a", 1'b0, 8'hA5, 1'b1, 4'd3, 1'b1,
                8'b1010_0000, 3, 8'h2F);
        rsp_ready = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check_eq("bp_rsp_data", 32'(rsp_data), 32'h2F);
            check_eq("bp_rsp_id", 32'(rsp_id), 32'h0);
            check_eq("bp_rdy", 32'({a_ready, b_ready}), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("hs_rdy", 32'({a_ready, b_ready}), 32'h0);
        check_eq("hs_rsp_valid", 32'(rsp_valid), 32'h1);
        tick();
        check_eq("hs_idle_rsp", 32'(rsp_valid), 32'h0);
        check_eq("hs_idle_grant_b", 32'({a_ready, b_ready}), 32'h1);
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        tick();

        // Right shift, B only, len 0 runs 8 cycles
        run_job("right_b", 1'b1, 8'h81, 1'b0, 4'd0, 1'b0,
                8'b1000_0001, 8, 8'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check_eq("right_b_release", 32'(rsp_valid), 32'h0);

        // Round-robin with both requesters held valid
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_len = 4'd1; b_len = 4'd1;
        rsp_ready = 1'b1;
        #1;
        ng = 0; both = 0; longp = 0; prev = 1'b0; gs = '0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            if (a_ready && b_ready) both++;
            if ((a_ready || b_ready) && prev) longp++;
            if (a_ready ^ b_ready) begin
                gs[ng] = b_ready;
                ng++;
            end
            prev = a_ready | b_ready;
            tick();
        end
        check_eq("rr_grants", 32'(ng), 32'h4);
        check_eq("rr_order", 32'(gs), 32'hA);
        check_eq("rr_both_high", 32'(both), 32'h0);
        check_eq("rr_long_pulse", 32'(longp), 32'h0);

        // Reset in the second shift cycle with pointer at B
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        a_valid = 1'b1; a_data = 8'h3C; a_left = 1'b1; a_len = 4'd5;
        #1;
        check_eq("mid_grant_a", 32'({a_ready, b_ready}), 32'h2);
        tick();
        a_valid = 1'b0;
        #1;
        check_eq("mid_shift1", 32'(sdo_valid), 32'h1);
        tick();
        check_eq("mid_shift2", 32'(sdo_valid), 32'h1);
        reset_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        tick();
        check_eq("mid_reset_outs", all_out(), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mid_reset_hold", all_out(), 32'h0);
        end
        reset_n = 1'b1;
        #1;
        check_eq("post_reset_grant_a", 32'({a_ready, b_ready}), 32'h2);
        check_eq("post_reset_rsp", 32'(rsp_valid), 32'h0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
